// File: rtl/uart_tx_fifo_if.sv
// Producer/UART-side signal bundle for uart_tx_fifo: byte enqueue port,
// AXI-stream style head output, and fill/overflow status for debug.
interface uart_tx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              full;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  // Environment side: byte producer plus the UART transmitter.
  modport master (
    output wr_data,
    output wr_en,
    output m_tready,
    input  full,
    input  m_tdata,
    input  m_tvalid,
    input  count,
    input  overflow
  );

  // FIFO side.
  modport slave (
    input  wr_data,
    input  wr_en,
    input  m_tready,
    output full,
    output m_tdata,
    output m_tvalid,
    output count,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter, with fill
// level and sticky overflow. Optional CR insertion before LF: UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              tvalid_r;
  logic              overflow_r;

  logic              wr_acc_s;
  logic              wr_drop_s;
  logic              hs_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] tdata_s;

  assign head_s    = mem_r[rd_ptr_r];
  assign wr_acc_s  = bus.wr_en & ~full_r;
  // A pop in the same cycle never makes room for a write seen while full.
  assign wr_drop_s = bus.wr_en & full_r;
  assign hs_s      = tvalid_r & bus.m_tready;

`ifdef UART_TX_FIFO_CRLF_EN
  logic cr_sent_r;
  logic insert_cr_s;

  assign insert_cr_s = tvalid_r & (head_s == DATA_W'(8'h0A)) & ~cr_sent_r;

  // Pop decision and presented byte when a CR is injected ahead of each LF.
  always_comb begin
    pop_s   = 1'b0;
    tdata_s = {DATA_W{1'b0}};
    if (hs_s && !insert_cr_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (!tvalid_r) begin
      tdata_s = {DATA_W{1'b0}};
    end else if (insert_cr_s) begin
      tdata_s = DATA_W'(8'h0D);
    end else begin
      tdata_s = head_s;
    end
  end

  // CR-sent flag: set by the CR handshake, cleared when the LF itself pops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_sent_r <= 1'b0;
    end else if (hs_s && insert_cr_s) begin
      cr_sent_r <= 1'b1;
    end else if (pop_s) begin
      cr_sent_r <= 1'b0;
    end else begin
      cr_sent_r <= cr_sent_r;
    end
  end
`else
  // Pop on every handshake; head byte passes through unmodified.
  always_comb begin
    pop_s   = hs_s;
    tdata_s = {DATA_W{1'b0}};
    if (tvalid_r) begin
      tdata_s = head_s;
    end else begin
      tdata_s = {DATA_W{1'b0}};
    end
  end
`endif

  // Next fill level from accepted write and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers, level, full/valid flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      tvalid_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_W'(DEPTH));
      tvalid_r   <= (count_nxt_s != {CNT_W{1'b0}});
      overflow_r <= overflow_r | wr_drop_s;
    end
  end

  assign bus.full     = full_r;
  assign bus.m_tvalid = tvalid_r;
  assign bus.m_tdata  = tdata_s;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed, table-driven bench for uart_tx_fifo (DEPTH=16, DATA_W=8),
// with hand-written sequences for fill/overflow, wrap, reset and CRLF.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(16), .DATA_W(8)) bus ();

  uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] d, input logic rdy);
    bus.wr_en    = we;
    bus.wr_data  = d;
    bus.m_tready = rdy;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (cycles) tick();
    chk("rst_valid", {31'd0, bus.m_tvalid}, 32'd0);
    chk("rst_data", {24'd0, bus.m_tdata}, 32'd0);
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    #1;

    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 5'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h43, 1'b1, 1'b1, 8'h43, 5'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h43, 5'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    do_reset(2);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wr_en, tbl[i].wr_data, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'd0, bus.m_tvalid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_data", i), {24'd0, bus.m_tdata}, {24'd0, tbl[i].e_data});
      chk($sformatf("tbl%0d_count", i), {27'd0, bus.count}, {27'd0, tbl[i].e_count});
      chk($sformatf("tbl%0d_full", i), {31'd0, bus.full}, {31'd0, tbl[i].e_full});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, tbl[i].e_ovf});
    end

    // Fill to DEPTH with 00..0F while the UART stalls.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
      chk("fill_count", {27'd0, bus.count}, 32'(i + 1));
      chk("fill_full", {31'd0, bus.full}, (i == 15) ? 32'd1 : 32'd0);
      chk("fill_head", {24'd0, bus.m_tdata}, 32'h00);
    end
    // Write while full with a same-cycle pop: dropped, overflow set.
    drive(1'b1, 8'hFF, 1'b1);
    tick();
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    chk("ovf_count", {27'd0, bus.count}, 32'd15);
    chk("ovf_full", {31'd0, bus.full}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);

    exp_q.delete();
    for (int j = 1; j < 16; j++) begin
`ifdef UART_TX_FIFO_CRLF_EN
      if (j == 10) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'(j));
    end
    foreach (exp_q[k]) begin
      chk("drain_valid", {31'd0, bus.m_tvalid}, 32'd1);
      chk("drain_data", {24'd0, bus.m_tdata}, {24'd0, exp_q[k]});
      bus.m_tready = 1'b1;
      tick();
      bus.m_tready = 1'b0;
    end
    chk("drain_empty", {31'd0, bus.m_tvalid}, 32'd0);
    chk("drain_count", {27'd0, bus.count}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Streaming: 40 bytes, 1-cycle latency, pointers wrap twice.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b1);
      tick();
      chk("stream_valid", {31'd0, bus.m_tvalid}, 32'd1);
      chk("stream_data", {24'd0, bus.m_tdata}, 32'(8'h60 + i));
      chk("stream_count", {27'd0, bus.count}, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("stream_end_count", {27'd0, bus.count}, 32'd0);
    chk("stream_end_valid", {31'd0, bus.m_tvalid}, 32'd0);

    // Mid-operation reset discards queued bytes and clears overflow.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h31 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("mid_head", {24'd0, bus.m_tdata}, 32'h31);
    chk("mid_count", {27'd0, bus.count}, 32'd5);
    do_reset(1);
    drive(1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("post_rst_data", {24'd0, bus.m_tdata}, 32'h55);
    chk("post_rst_count", {27'd0, bus.count}, 32'd1);
    bus.m_tready = 1'b1;
    tick();
    chk("post_rst_empty", {27'd0, bus.count}, 32'd0);

    // CRLF handling on 48, 0A.
    drive(1'b1, 8'h48, 1'b0);
    tick();
    drive(1'b1, 8'h0A, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("crlf_count0", {27'd0, bus.count}, 32'd2);
    chk("crlf_d0", {24'd0, bus.m_tdata}, 32'h48);
    tick();
    chk("crlf_count1", {27'd0, bus.count}, 32'd1);
`ifdef UART_TX_FIFO_CRLF_EN
    chk("crlf_d1", {24'd0, bus.m_tdata}, 32'h0D);
    tick();
    chk("crlf_count2", {27'd0, bus.count}, 32'd1);
    chk("crlf_d2", {24'd0, bus.m_tdata}, 32'h0A);
`else
    chk("crlf_d1", {24'd0, bus.m_tdata}, 32'h0A);
`endif
    tick();
    chk("crlf_count_end", {27'd0, bus.count}, 32'd0);
    chk("crlf_valid_end", {31'd0, bus.m_tvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the design's transmit-byte producer and the UART transmitter's AXI-stream input (`input_axis_tdata`/`tvalid`/`tready`).
- Absorbs bursts so the producer can post bytes faster than the serial line drains them.
- Single clock domain: the serial clock that runs the UART.
- Reports fill level and a sticky overflow flag for debug display.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- DATA_W, 8, width of each entry in bits.

Ports:
- clk  input  1  serial clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_data  input  DATA_W  byte to enqueue.
- wr_en  input  1  enqueue request; one byte per cycle while high.
- full  output  1  high when count == DEPTH.
- m_tdata  output  DATA_W  head byte presented to the UART.
- m_tvalid  output  1  head byte valid.
- m_tready  input  1  UART accepts the head byte this cycle.
- count  output  $clog2(DEPTH)+1  number of stored bytes.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - Therefore full=0, m_tvalid=0, m_tdata=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes, including a byte currently being presented.
- Storage:
  - DEPTH x DATA_W register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write:
  - Accepted iff wr_en=1 and full=0, where full is sampled before the edge.
  - On accept: mem[wr_ptr] <= wr_data, wr_ptr increments.
- Write while full:
  - Byte is dropped and overflow <= 1.
  - This holds even if a read occurs in the same cycle; a pop does not create room for a same-cycle write.
- Read:
  - Handshake occurs when m_tvalid=1 and m_tready=1 at the edge.
  - On handshake: rd_ptr increments.
- Output timing:
  - First-word fall-through: m_tvalid = (count != 0).
  - m_tdata = mem[rd_ptr] when m_tvalid=1, otherwise 0.
  - m_tdata and m_tvalid are driven from registered state only; no combinational path from wr_en or wr_data.
- Latency: a byte written at edge N is visible on m_tdata/m_tvalid after edge N, so it can be handshaken at edge N+1 at the earliest.
- Stability: while m_tvalid=1 and m_tready=0, m_tdata and m_tvalid hold until the handshake.
- Count update: count' = count + accepted_write - handshake.
  - Simultaneous accepted write and handshake leaves count unchanged.
  - Simultaneous write and read when empty: write accepted, no handshake (m_tvalid was 0), count becomes 1.
- Boundaries:
  - count never exceeds DEPTH and never underflows.
  - full is asserted exactly when count == DEPTH.
- overflow: cleared only by reset.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN.
- With the macro defined:
  - Adds a 1-bit register cr_sent (reset 0).
  - When the head byte is 8'h0A and cr_sent=0, the FIFO presents m_tdata=8'h0D with m_tvalid=1.
  - On that handshake: cr_sent <= 1; no pop; count unchanged.
  - It then presents 8'h0A; on that handshake the entry pops and cr_sent <= 0.
  - count reflects stored entries only; the inserted CR is not counted.
  - Reset clears cr_sent.
- Without the macro: no cr_sent register; bytes pass through unmodified.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → m_tvalid=0, m_tdata=0, count=0, full=0, overflow=0.
- Single byte: write 8'h41 at edge N with m_tready=0 → after N, m_tvalid=1, m_tdata=8'h41, count=1; hold 5 cycles stable; raise m_tready → pop, m_tvalid=0, count=0.
- Fill and overflow (DEPTH=16): write 8'h00..8'h0F → full=1, count=16; write 8'hFF with m_tready=1 the same cycle → byte dropped, overflow=1, count=15; drain → outputs 8'h00..8'h0F in order, no 8'hFF.
- Streaming wrap-around: m_tready=1 continuously; write 40 incrementing bytes one per cycle → output matches in order with 1-cycle latency, count stays at most 1, pointers wrap twice.
- Mid-operation reset: 5 bytes queued and head presented, assert rst_n=0 for 1 cycle → count=0, m_tvalid=0, overflow=0; next write 8'h55 emerges as first byte.
- CRLF (macro defined): write 8'h48, 8'h0A, m_tready=1 → output stream 8'h48, 8'h0D, 8'h0A; count goes 2→1→1→0. Macro undefined → stream 8'h48, 8'h0A.
